// File: rtl/gpio_trace_monitor.sv
// GPIO/LED bus trace monitor: timestamps every bus change into a first-word-fall-through
// FIFO, emits heartbeat pulses with a sticky done flag, and flags idle timeouts.
module gpio_trace_monitor #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int TS_WIDTH     = 32,
    parameter int HEARTBEAT    = 50000,
    parameter int NUM_BEATS    = 16,
    parameter int IDLE_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic [WIDTH-1:0]    watch,
    output logic                heartbeat,
    output logic [15:0]         beat_count,
    output logic                done,
    output logic                rec_valid,
    input  logic                rec_ready,
    output logic [WIDTH-1:0]    rec_value,
    output logic [TS_WIDTH-1:0] rec_time,
    output logic                overflow,
    output logic [15:0]         drop_count,
    output logic                timeout
);

    localparam int AW     = $clog2(DEPTH);
    localparam int BEAT_W = $clog2(HEARTBEAT);
    localparam int IDLE_W = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);

    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(HEARTBEAT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_TIMEOUT);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } hb_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic                active;
    logic                change;
    logic [WIDTH-1:0]    watch_q;
    logic [TS_WIDTH-1:0] ts;

    hb_state_t           state;
    hb_state_t           state_d;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   beat_cnt_d;
    logic [15:0]         beat_count_d;
    logic                heartbeat_d;

    logic [WIDTH-1:0]    mem_value [DEPTH];
    logic [TS_WIDTH-1:0] mem_time  [DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic                fifo_empty;
    logic                fifo_full;
    logic                pop;
    logic                push_ok;
    logic                drop;

    logic [IDLE_W-1:0]   idle_cnt;
    logic [IDLE_W-1:0]   idle_inc;

    assign done   = (state == DONE);
    assign active = enable & ~done;
    assign change = active & (watch != watch_q);

    // ---- change detection and timestamp ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            watch_q <= '0;
            ts      <= '0;
        end else begin
            watch_q <= watch;
            if (active) begin
                ts <= ts + TS_WIDTH'(1);
            end
        end
    end

    // ---- heartbeat FSM ----
    always_comb begin
        state_d      = state;
        beat_cnt_d   = beat_cnt;
        beat_count_d = beat_count;
        heartbeat_d  = 1'b0;
        case (state)
            RUN: begin
                if (active) begin
                    if (beat_cnt == BEAT_LAST) begin
                        beat_cnt_d   = '0;
                        heartbeat_d  = 1'b1;
                        beat_count_d = sat_inc16(beat_count);
                        if ((NUM_BEATS != 0) && (32'(beat_count_d) == NUM_BEATS)) begin
                            state_d = DONE;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt + BEAT_W'(1);
                    end
                end
            end
            DONE: state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= RUN;
            beat_cnt   <= '0;
            beat_count <= '0;
            heartbeat  <= 1'b0;
        end else begin
            state      <= state_d;
            beat_cnt   <= beat_cnt_d;
            beat_count <= beat_count_d;
            heartbeat  <= heartbeat_d;
        end
    end

    // ---- trace FIFO ----
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rec_valid  = ~fifo_empty;
    assign pop        = rec_valid & rec_ready;
    // A pop frees the head slot this edge, so a push into a full FIFO is still accepted.
    assign push_ok    = change & (~fifo_full | pop);
    assign drop       = change & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_value[wr_ptr[AW-1:0]] <= watch;
            mem_time[wr_ptr[AW-1:0]]  <= ts;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc16(drop_count);
            end
        end
    end

    // Storage is not reset, so the head is masked to keep outputs at zero while empty.
    assign rec_value = rec_valid ? mem_value[rd_ptr[AW-1:0]] : '0;
    assign rec_time  = rec_valid ? mem_time[rd_ptr[AW-1:0]]  : '0;

    // ---- idle timeout ----
    assign idle_inc = idle_cnt + IDLE_W'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (!active || change) begin
            idle_cnt <= '0;
        end else if ((IDLE_TIMEOUT != 0) && (idle_cnt != IDLE_LIMIT)) begin
            idle_cnt <= idle_inc;
            if (idle_inc == IDLE_LIMIT) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule
